pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder_if.sv | 38 +++
 rtl/pipe_adder.sv | 119 +++++++++++
 tb/tb_pipe_adder.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder.
// The Sat lane exists only when PIPE_ADDER_SAT_EN is defined.
interface pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
`ifdef PIPE_ADDER_SAT_EN
  logic             Sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             V;

  modport master (
    output in_valid, A, B, Cin, Sub,
`ifdef PIPE_ADDER_SAT_EN
    output Sat,
`endif
    output out_ready,
    input  in_ready, out_valid, S, Cout, V
  );

  modport slave (
    input  in_valid, A, B, Cin, Sub,
`ifdef PIPE_ADDER_SAT_EN
    input  Sat,
`endif
    input  out_ready,
    output in_ready, out_valid, S, Cout, V
  );
endinterface

// File: rtl/pipe_adder.sv
// Pipelined add/subtract with the carry chain cut into STAGES slices, LSB first.
// Optional saturation on signed overflow is enabled by defining PIPE_ADDER_SAT_EN.
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic         clk,
  input logic         rst,
  pipe_adder_if.slave bus
);

  localparam int SW   = (WIDTH + STAGES - 1) / STAGES;
  localparam int LAST = STAGES - 1;

  // Partial result travelling down the pipe: summed bits so far, carry into
  // the next slice, and the carry into the MSB once that bit has been summed.
  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             cm;
  } slice_t;

  // Ripple the bits belonging to slice k; other bits pass through untouched.
  function automatic slice_t slice_add(input int k, input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b, input slice_t prev);
    slice_t r;
    r = prev;
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= k * SW && i < (k + 1) * SW) begin
        r.s[i] = a[i] ^ b[i] ^ r.c;
        if (i == WIDTH - 1) r.cm = r.c;
        r.c = (a[i] & b[i]) | (r.c & (a[i] ^ b[i]));
      end
    end
    return r;
  endfunction

`ifdef PIPE_ADDER_SAT_EN
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic   sat_q [STAGES];
  logic   sat_n [STAGES];
`endif

  logic             v_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  slice_t           r_q [STAGES];
  logic             ov_q;

  logic             v_n [STAGES];
  logic [WIDTH-1:0] a_n [STAGES];
  logic [WIDTH-1:0] b_n [STAGES];
  slice_t           r_n [STAGES];
  logic             ov_n;
  logic             adv;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. The whole pipe moves as one; it advances exactly when in_ready.
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    // Subtraction is A + ~B + ~Cin, so the operand is inverted once at entry.
    v_n[0] = bus.in_valid;
    a_n[0] = bus.A;
    b_n[0] = bus.Sub ? ~bus.B : bus.B;
    r_n[0] = slice_add(0, a_n[0], b_n[0],
                       {{WIDTH{1'b0}}, (bus.Sub ? ~bus.Cin : bus.Cin), 1'b0});
    for (int k = 1; k < STAGES; k++) begin
      v_n[k] = v_q[k-1];
      a_n[k] = a_q[k-1];
      b_n[k] = b_q[k-1];
      r_n[k] = slice_add(k, a_q[k-1], b_q[k-1], r_q[k-1]);
    end
    ov_n = r_n[LAST].cm ^ r_n[LAST].c;
`ifdef PIPE_ADDER_SAT_EN
    sat_n[0] = bus.Sat;
    for (int k = 1; k < STAGES; k++) begin
      sat_n[k] = sat_q[k-1];
    end
    if (sat_n[LAST] && ov_n) begin
      r_n[LAST].s = r_n[LAST].s[WIDTH-1] ? MAX_POS : MIN_NEG;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
`ifdef PIPE_ADDER_SAT_EN
        sat_q[k] <= 1'b0;
`endif
      end
      ov_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_n[k];
        a_q[k] <= a_n[k];
        b_q[k] <= b_n[k];
        r_q[k] <= r_n[k];
`ifdef PIPE_ADDER_SAT_EN
        sat_q[k] <= sat_n[k];
`endif
      end
      ov_q <= ov_n;
    end
  end

  assign bus.out_valid = v_q[LAST];
  assign bus.S         = r_q[LAST].s;
  assign bus.Cout      = r_q[LAST].c;
  assign bus.V         = ov_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: directed vectors on a 16-bit/4-stage build,
// plus random traffic on 16-bit/1-stage and 13-bit/4-stage builds.
module tb_pipe_adder;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_stall  = 0;
  int   lat;

  pipe_adder_if #(.WIDTH(16)) bus ();
  pipe_adder_if #(.WIDTH(16)) bus1 ();
  pipe_adder_if #(.WIDTH(13)) bus13 ();

  pipe_adder #(.WIDTH(16), .STAGES(4)) dut   (.clk(clk), .rst(rst), .bus(bus));
  pipe_adder #(.WIDTH(16), .STAGES(1)) dut1  (.clk(clk), .rst(rst), .bus(bus1));
  pipe_adder #(.WIDTH(13), .STAGES(4)) dut13 (.clk(clk), .rst(rst), .bus(bus13));

  logic [17:0] exp_q[$];
  logic [17:0] exp1_q[$];
  logic [14:0] exp13_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, expected none at %0t", name, act, $time);
  endtask

  // Reference: {S, Cout, V} in the low w+2 bits; V from the operand/result sign rule.
  function automatic logic [65:0] ref_add(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub);
    logic [63:0] mask, am, bx, s;
    logic [64:0] full;
    logic        ci, v;
    mask = (64'd1 << w) - 64'd1;
    am   = a & mask;
    bx   = sub ? (~b & mask) : (b & mask);
    ci   = sub ? ~cin : cin;
    full = {1'b0, am} + {1'b0, bx} + {64'd0, ci};
    s    = full[63:0] & mask;
    v    = (am[w-1] == bx[w-1]) && (s[w-1] != am[w-1]);
    return {s, full[w], v};
  endfunction

  // driver tasks (main DUT); called at posedge+1, return at posedge+1 after accept
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic sub, input logic sat, input logic [17:0] exp);
    int guard = 0;
    bus.in_valid = 1'b1;
    bus.A = a;
    bus.B = b;
    bus.Cin = cin;
    bus.Sub = sub;
`ifdef PIPE_ADDER_SAT_EN
    bus.Sat = sat;
`endif
    #1;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #2;
      guard++;
    end
    if (guard >= 100) fail_now("send_timeout", {63'd0, sat});
    else exp_q.push_back(exp);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_latency(output int l);
    l = 1;
    while (!bus.out_valid && l < 50) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic drain(input string name);
    int g = 0;
    while ((exp_q.size() + exp1_q.size() + exp13_q.size()) != 0 && g < 400) begin
      @(posedge clk); #1;
      g++;
    end
    check({"drain_", name}, exp_q.size() + exp1_q.size() + exp13_q.size(), 0);
  endtask

  task automatic run_rand1();
    int n = 0;
    int g = 0;
    while (n < 1000 && g < 20000) begin
      @(posedge clk); #1;
      g++;
      bus1.in_valid  = ($urandom_range(0, 3) != 0);
      bus1.out_ready = ($urandom_range(0, 3) != 0);
      bus1.A   = 16'($urandom);
      bus1.B   = 16'($urandom);
      bus1.Cin = 1'($urandom_range(0, 1));
      bus1.Sub = 1'($urandom_range(0, 1));
      #1;
      if (bus1.in_valid && bus1.in_ready) begin
        exp1_q.push_back(18'(ref_add(16, 64'(bus1.A), 64'(bus1.B), bus1.Cin, bus1.Sub)));
        n++;
      end
    end
    @(posedge clk); #1;
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
  endtask

  task automatic run_rand13();
    int n = 0;
    int g = 0;
    while (n < 1000 && g < 20000) begin
      @(posedge clk); #1;
      g++;
      bus13.in_valid  = ($urandom_range(0, 3) != 0);
      bus13.out_ready = ($urandom_range(0, 3) != 0);
      bus13.A   = 13'($urandom);
      bus13.B   = 13'($urandom);
      bus13.Cin = 1'($urandom_range(0, 1));
      bus13.Sub = 1'($urandom_range(0, 1));
      #1;
      if (bus13.in_valid && bus13.in_ready) begin
        exp13_q.push_back(15'(ref_add(13, 64'(bus13.A), 64'(bus13.B), bus13.Cin, bus13.Sub)));
        n++;
      end
    end
    @(posedge clk); #1;
    bus13.in_valid  = 1'b0;
    bus13.out_ready = 1'b1;
  endtask

  // scoreboard monitors
  logic [17:0] held_val;
  logic        held = 1'b0;

  always @(negedge clk) begin : mon_main
    logic [17:0] cur;
    cur = {bus.S, bus.Cout, bus.V};
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) check("hold_outputs", {bus.out_valid, cur}, {1'b1, held_val});
      if (bus.out_valid && !bus.out_ready) begin
        n_stall++;
        check("in_ready_stall", bus.in_ready, 0);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_result", cur);
        else check("result", cur, exp_q.pop_front());
      end
      held     = bus.out_valid && !bus.out_ready;
      held_val = cur;
    end
  end

  always @(negedge clk) begin : mon_s1
    if (!rst && bus1.out_valid && bus1.out_ready) begin
      if (exp1_q.size() == 0) fail_now("unexpected_s1", {bus1.S, bus1.Cout, bus1.V});
      else check("result_s1", {bus1.S, bus1.Cout, bus1.V}, exp1_q.pop_front());
    end
  end

  always @(negedge clk) begin : mon_w13
    if (!rst && bus13.out_valid && bus13.out_ready) begin
      if (exp13_q.size() == 0) fail_now("unexpected_w13", {bus13.S, bus13.Cout, bus13.V});
      else check("result_w13", {bus13.S, bus13.Cout, bus13.V}, exp13_q.pop_front());
    end
  end

  initial begin
    #5000000;
    fail_now("watchdog", 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;   bus.A = '0;   bus.B = '0;   bus.Cin = 1'b0;   bus.Sub = 1'b0;
    bus1.in_valid = 1'b0;  bus1.A = '0;  bus1.B = '0;  bus1.Cin = 1'b0;  bus1.Sub = 1'b0;
    bus13.in_valid = 1'b0; bus13.A = '0; bus13.B = '0; bus13.Cin = 1'b0; bus13.Sub = 1'b0;
`ifdef PIPE_ADDER_SAT_EN
    bus.Sat = 1'b0; bus1.Sat = 1'b0; bus13.Sat = 1'b0;
`endif
    bus.out_ready = 1'b1; bus1.out_ready = 1'b1; bus13.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_S", bus.S, 0);
    check("rst_Cout", bus.Cout, 0);
    check("rst_V", bus.V, 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // first add and its latency
    send(16'h0005, 16'h0007, 1'b0, 1'b0, 1'b0, {16'h000C, 1'b0, 1'b0});
    idle();
    wait_latency(lat);
    check("latency_add", lat, 4);
    drain("first_add");

    // directed add / overflow / subtract vectors, back to back
    send(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, {16'h0001, 1'b1, 1'b0});
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1});
`ifdef PIPE_ADDER_SAT_EN
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, {16'h7FFF, 1'b0, 1'b1});
    send(16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b1, {16'h8000, 1'b1, 1'b1});
`else
    send(16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b1, {16'h7FFF, 1'b1, 1'b1});
`endif
    send(16'h0003, 16'h0005, 1'b0, 1'b1, 1'b0, {16'hFFFE, 1'b0, 1'b0});
    send(16'h0009, 16'h0006, 1'b1, 1'b1, 1'b0, {16'h0002, 1'b1, 1'b0});
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, {16'h7FFF, 1'b1, 1'b1});
    idle();
    drain("directed");

    // backpressure: 8 back-to-back ops with a 3-cycle consumer stall
    fork
      begin
        for (int k = 1; k <= 8; k++) begin
          send(16'(k * 32'h1001), 16'h0010, 1'(k), 1'b0, 1'b0,
               18'(ref_add(16, 64'(k * 32'h1001), 64'h10, 1'(k), 1'b0)));
        end
        idle();
      end
      begin
        repeat (6) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain("backpressure");
    check("stall_cycles", n_stall, 3);

    // reset with 3 ops in flight; an op offered during reset must be ignored
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, {16'h3333, 1'b0, 1'b0});
    send(16'h0100, 16'h0001, 1'b0, 1'b1, 1'b0, {16'h00FF, 1'b1, 1'b0});
    send(16'h4000, 16'h4000, 1'b0, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1});
    bus.A = 16'hAAAA;
    bus.B = 16'h5555;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    check("rst_mid_out_valid", bus.out_valid, 0);
    check("rst_mid_in_ready", bus.in_ready, 1);
    repeat (8) @(posedge clk);
    #1;
    send(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, {16'h5555, 1'b0, 1'b0});
    idle();
    wait_latency(lat);
    check("latency_after_rst", lat, 4);
    drain("after_rst");

    // random traffic on the single-stage and uneven-slice builds
    fork
      run_rand1();
      run_rand13();
    join
    drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
